// File: rtl/trng_gf16_column_mixer_pkg.sv
// GF(2^4) arithmetic (poly x^4+x+1), circulant mixing coefficients and mixer FSM encoding
// shared by the TRNG column mixer and its bit collector.
package trng_gf16_column_mixer_pkg;

   localparam logic [3:0] GF16_POLY = 4'h3;

   // Circulant row: out_i = C0*a_i ^ C1*a_(i+1) ^ C2*a_(i+2) ^ C3*a_(i+3)
   localparam logic [3:0] MIX_C0 = 4'h5;
   localparam logic [3:0] MIX_C1 = 4'h2;
   localparam logic [3:0] MIX_C2 = 4'h1;
   localparam logic [3:0] MIX_C3 = 4'h1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MIX  = 2'd1,
      ST_HOLD = 2'd2
   } mix_state_e;

   function automatic logic [3:0] gf16_mul2(input logic [3:0] d);
      return {d[2:0], 1'b0} ^ (d[3] ? GF16_POLY : 4'h0);
   endfunction

   function automatic logic [3:0] gf16_mul5(input logic [3:0] d);
      return gf16_mul2(gf16_mul2(d)) ^ d;
   endfunction

   // Only the coefficients present in the circulant row are supported.
   function automatic logic [3:0] gf16_mul_coef(input logic [3:0] d, input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'h1:    r = d;
         4'h2:    r = gf16_mul2(d);
         4'h5:    r = gf16_mul5(d);
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   // Nibble k of a column; a0 sits in the top nibble.
   function automatic logic [3:0] col_nibble(input logic [15:0] col, input logic [1:0] k);
      logic [3:0] n;
      case (k)
         2'd0:    n = col[15:12];
         2'd1:    n = col[11:8];
         2'd2:    n = col[7:4];
         default: n = col[3:0];
      endcase
      return n;
   endfunction

   function automatic logic [3:0] mix_nibble(input logic [15:0] col, input logic [1:0] i);
      logic [1:0] i1;
      logic [1:0] i2;
      logic [1:0] i3;
      i1 = i + 2'd1;
      i2 = i + 2'd2;
      i3 = i + 2'd3;
      return gf16_mul_coef(col_nibble(col, i),  MIX_C0)
           ^ gf16_mul_coef(col_nibble(col, i1), MIX_C1)
           ^ gf16_mul_coef(col_nibble(col, i2), MIX_C2)
           ^ gf16_mul_coef(col_nibble(col, i3), MIX_C3);
   endfunction

endpackage

// File: rtl/trng_bit_collector.sv
// Packs raw TRNG bits MSB-first into a 16-bit column, holds it until taken, and counts
// bits dropped while full (saturating). A bit arriving on the take edge starts the next column.
module trng_bit_collector
   import trng_gf16_column_mixer_pkg::*;
#(
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  raw_bit,
   input  logic                  raw_valid,
   input  logic                  take,
   output logic [15:0]           column,
   output logic                  full,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   logic [15:0]           shift_q;
   logic [3:0]            cnt_q;
   logic                  full_q;
   logic [DROP_CNT_W-1:0] drop_q;
   logic                  accept;
   logic                  drop;

   assign accept = raw_valid && (!full_q || take);
   assign drop   = raw_valid && full_q && !take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= 16'h0000;
         cnt_q   <= 4'd0;
         full_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         // Shifting in at the LSB leaves the first of 16 bits at [15].
         if (accept) begin
            shift_q <= {shift_q[14:0], raw_bit};
         end
         if (take) begin
            full_q <= 1'b0;
            cnt_q  <= accept ? 4'd1 : 4'd0;
         end else if (accept) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'hF) begin
               full_q <= 1'b1;
            end
         end
         if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
         end
      end
   end

   assign column   = shift_q;
   assign full     = full_q;
   assign drop_cnt = drop_q;

endmodule

// File: rtl/trng_gf16_column_mixer.sv
// TRNG column mixer: collects 16 raw bits, applies a circulant GF(2^4) matrix one nibble per
// cycle (5 cycles from the 16th bit to OUT_VALID), holds the result until OUT_READY; raw bits
// arriving while a column is pending are dropped. TRNG_GF16_MIXER_CHAIN_EN xors in the last output.
module trng_gf16_column_mixer
   import trng_gf16_column_mixer_pkg::*;
#(
   parameter int DROP_CNT_W = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RAW_BIT,
   input  logic                  RAW_VALID,
   output logic [15:0]           OUT_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic                  BUSY,
   output logic [DROP_CNT_W-1:0] DROP_CNT
);

   mix_state_e  state_q;
   mix_state_e  state_d;
   logic [1:0]  idx_q;
   logic [15:0] mix_in_q;
   logic [15:0] out_data_q;
   logic        out_valid_q;
   logic [15:0] col;
   logic        col_full;
   logic [15:0] mix_src;
   logic [3:0]  mixed;
   logic        xfer;
   logic        mix_en;
   logic        hs;

   trng_bit_collector #(
      .DROP_CNT_W (DROP_CNT_W)
   ) u_collector (
      .clk       (CLK),
      .rst       (RST),
      .raw_bit   (RAW_BIT),
      .raw_valid (RAW_VALID),
      .take      (xfer),
      .column    (col),
      .full      (col_full),
      .drop_cnt  (DROP_CNT)
   );

`ifdef TRNG_GF16_MIXER_CHAIN_EN
   logic [15:0] chain_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         chain_q <= 16'h0000;
      end else if (hs) begin
         chain_q <= out_data_q;
      end
   end

   assign mix_src = col ^ chain_q;
`else
   assign mix_src = col;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // HOLD only returns to IDLE, so a pending column waits one bubble cycle after a handshake.
   always_comb begin
      state_d = state_q;
      xfer    = 1'b0;
      mix_en  = 1'b0;
      hs      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (col_full) begin
               xfer    = 1'b1;
               state_d = ST_MIX;
            end
         end
         ST_MIX: begin
            mix_en = 1'b1;
            if (idx_q == 2'd3) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_valid_q && OUT_READY) begin
               hs      = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mixed = mix_nibble(mix_in_q, idx_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q       <= 2'd0;
         mix_in_q    <= 16'h0000;
         out_data_q  <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         if (xfer) begin
            mix_in_q <= mix_src;
            idx_q    <= 2'd0;
         end
         if (mix_en) begin
            case (idx_q)
               2'd0:    out_data_q[15:12] <= mixed;
               2'd1:    out_data_q[11:8]  <= mixed;
               2'd2:    out_data_q[7:4]   <= mixed;
               default: out_data_q[3:0]   <= mixed;
            endcase
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               out_valid_q <= 1'b1;
            end
         end
         if (hs) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trng_gf16_column_mixer.sv
// Bench for trng_gf16_column_mixer: directed columns, backpressure/drop, saturation, async reset,
// then randomized traffic against a transaction-level model.
module tb_trng_gf16_column_mixer;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          raw_bit;
   logic          raw_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic          out_valid;
   logic          busy;
   logic [DW-1:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   trng_gf16_column_mixer #(
      .DROP_CNT_W (DW)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .RAW_BIT   (raw_bit),
      .RAW_VALID (raw_valid),
      .OUT_DATA  (out_data),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .BUSY      (busy),
      .DROP_CNT  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Generic carry-less multiply then reduction by x^4+x+1.
   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 0; k < 4; k++) if (b[k]) p = p ^ ({4'h0, a} << k);
      for (int k = 7; k >= 4; k--) if (p[k]) p = p ^ (8'h13 << (k - 4));
      return p[3:0];
   endfunction

   function automatic logic [15:0] mix(input logic [15:0] c);
      int         coef [4];
      logic [3:0] a [4];
      logic [3:0] acc;
      logic [15:0] r;
      coef = '{5, 2, 1, 1};
      r = 16'h0000;
      for (int i = 0; i < 4; i++) a[i] = c[15 - 4*i -: 4];
      for (int i = 0; i < 4; i++) begin
         acc = 4'h0;
         for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], 4'(coef[(j - i + 4) % 4]));
         r[15 - 4*i -: 4] = acc;
      end
      return r;
   endfunction

   // Transaction-level model: pending column, mixer countdown, hold/handshake, drop count.
   int          m_cnt, m_mix_left, m_drops;
   bit          m_full, m_hold, m_xfer;
   logic [15:0] m_col, m_in, m_out, m_chain;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_cnt = 0; m_mix_left = 0; m_drops = 0;
         m_full = 0; m_hold = 0;
         m_col = 16'h0; m_in = 16'h0; m_out = 16'h0; m_chain = 16'h0;
      end else begin
         m_xfer = m_full && (m_mix_left == 0) && !m_hold;
         if (m_hold && out_ready) begin
            m_hold  = 0;
            m_chain = m_out;
         end
         if (m_mix_left > 0) begin
            m_mix_left--;
            if (m_mix_left == 0) begin
               m_hold = 1;
               m_out  = mix(m_in);
            end
         end
         if (m_xfer) begin
`ifdef TRNG_GF16_MIXER_CHAIN_EN
            m_in = m_col ^ m_chain;
`else
            m_in = m_col;
`endif
            m_mix_left = 4;
            m_full = 0;
            m_cnt  = 0;
         end
         if (raw_valid) begin
            if (!m_full) begin
               m_col[15 - m_cnt] = raw_bit;
               m_cnt++;
               if (m_cnt == 16) m_full = 1;
            end else if (m_drops < (1 << DW) - 1) begin
               m_drops++;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("cyc_valid", {31'd0, out_valid}, {31'd0, m_hold});
         chk("cyc_busy", {31'd0, busy}, {31'd0, (m_mix_left > 0) || m_hold});
         chk("cyc_drops", 32'(drop_cnt), 32'(m_drops));
         if (m_hold) chk("cyc_data", {16'd0, out_data}, {16'd0, m_out});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      raw_valid = 1'b0;
      raw_bit   = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // mode: 0 zeros, 1 ones, 2 random, 3 single one in bit position 3
   task automatic send(input int n, input int mode);
      for (int k = 0; k < n; k++) begin
         raw_valid = 1'b1;
         case (mode)
            0:       raw_bit = 1'b0;
            1:       raw_bit = 1'b1;
            3:       raw_bit = (k == 3);
            default: raw_bit = 1'($urandom_range(0, 1));
         endcase
         tick();
      end
      raw_valid = 1'b0;
   endtask

   task automatic column_test(input string name, input int mode, input logic [15:0] exp);
      int lat;
      do_reset();
      out_ready = 1'b1;
      send(16, mode);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'd5);
      chk({name, "_data"}, {16'd0, out_data}, {16'd0, exp});
   endtask

   initial begin
      rst       = 1'b1;
      raw_bit   = 1'b0;
      raw_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {16'd0, out_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drops", 32'(drop_cnt), 32'd0);

      chk("model_unit", {16'd0, mix(16'h1000)}, 32'h5112);
      chk("model_ones", {16'd0, mix(16'hFFFF)}, 32'hBBBB);

      column_test("zero", 0, 16'h0000);
      column_test("unit", 3, 16'h5112);
      column_test("ones", 1, 16'hBBBB);

      // Backpressure: one column held, one pending, the rest dropped.
      do_reset();
      out_ready = 1'b0;
      send(40, 2);
      repeat (3) tick();
      chk("bp_drops", 32'(drop_cnt), 32'd8);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_bubble_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("bp_xfer_busy", {31'd0, busy}, 32'd1);
      repeat (8) tick();

      // Saturation: 20 drops on a 4-bit counter.
      do_reset();
      out_ready = 1'b0;
      send(52, 2);
      tick();
      chk("sat_drops", 32'(drop_cnt), 32'hF);

      // Asynchronous reset while nibble 2 is being mixed.
      do_reset();
      out_ready = 1'b1;
      send(16, 1);
      repeat (3) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", {16'd0, out_data}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("mid_after_valid", {31'd0, out_valid}, 32'd0);

      // Random traffic with varying source density and consumer readiness.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         raw_valid = ($urandom_range(0, 7) < ((c / 500) % 4) + 4);
         raw_bit   = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) < ((c / 300) % 4) + 1);
         tick();
      end
      raw_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
